// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin selection among functional units feeding
// one registered broadcast slot that can drain and refill in the same cycle.
module cdb_arbiter #(
    parameter int NUM_SRC           = 4,
    parameter int BW_PROCESSOR_DATA = 32,
    parameter int BW_TAG            = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_SRC-1:0]                   i_src_rdy,
    output logic [NUM_SRC-1:0]                   o_src_ack,
    input  logic [NUM_SRC*BW_TAG-1:0]            i_src_tag_flatten,
    input  logic [NUM_SRC*BW_PROCESSOR_DATA-1:0] i_src_wdata_flatten,
    output logic                                 o_cdb_rdy,
    input  logic                                 i_cdb_ack,
    output logic [BW_TAG-1:0]                    o_cdb_tag,
    output logic [BW_PROCESSOR_DATA-1:0]         o_cdb_wdata,
    output logic [$clog2(NUM_SRC)-1:0]           o_cdb_src
);
    localparam int SW = $clog2(NUM_SRC);

    logic                         full_q;
    logic [BW_TAG-1:0]            tag_q;
    logic [BW_PROCESSOR_DATA-1:0] wdata_q;
    logic [SW-1:0]                src_q;
    logic [SW-1:0]                rr_ptr_q;
    logic [SW-1:0]                rr_ptr_d;

    logic          loadable;
    logic          gnt_vld;
    logic [SW-1:0] gnt_idx;

    assign loadable = !full_q || i_cdb_ack;

    // Scan from rr_ptr upward with wrap; the first requester wins.
    always_comb begin
        int            j;
        logic [SW-1:0] idx;
        j         = 0;
        idx       = '0;
        gnt_vld   = 1'b0;
        gnt_idx   = '0;
        o_src_ack = '0;
        if (loadable && !rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                j = int'(rr_ptr_q) + i;
                if (j >= NUM_SRC) j = j - NUM_SRC;
                idx = SW'(j);
                if (!gnt_vld && i_src_rdy[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = idx;
                end
            end
        end
        if (gnt_vld) o_src_ack[gnt_idx] = 1'b1;
    end

    assign rr_ptr_d = (gnt_idx == SW'(NUM_SRC - 1)) ? '0 : gnt_idx + SW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q   <= 1'b0;
            tag_q    <= '0;
            wdata_q  <= '0;
            src_q    <= '0;
            rr_ptr_q <= '0;
        end else if (gnt_vld) begin
            full_q   <= 1'b1;
            tag_q    <= i_src_tag_flatten[gnt_idx*BW_TAG +: BW_TAG];
            wdata_q  <= i_src_wdata_flatten[gnt_idx*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA];
            src_q    <= gnt_idx;
            rr_ptr_q <= rr_ptr_d;
        end else if (full_q && i_cdb_ack) begin
            full_q <= 1'b0;
        end
    end

    assign o_cdb_rdy   = full_q;
    assign o_cdb_tag   = tag_q;
    assign o_cdb_wdata = wdata_q;
    assign o_cdb_src   = src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: table of per-cycle vectors with hand-derived grants,
// and a queue of expected broadcasts checked one cycle after each grant.
module tb_cdb_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      i_src_rdy = '0;
    logic [N-1:0]      o_src_ack;
    logic [N*TW-1:0]   i_src_tag_flatten = '0;
    logic [N*DW-1:0]   i_src_wdata_flatten = '0;
    logic              o_cdb_rdy;
    logic              i_cdb_ack = 1'b0;
    logic [TW-1:0]     o_cdb_tag;
    logic [DW-1:0]     o_cdb_wdata;
    logic [1:0]        o_cdb_src;

    cdb_arbiter #(.NUM_SRC(N), .BW_PROCESSOR_DATA(DW), .BW_TAG(TW)) dut (
        .clk(clk), .rst(rst),
        .i_src_rdy(i_src_rdy), .o_src_ack(o_src_ack),
        .i_src_tag_flatten(i_src_tag_flatten), .i_src_wdata_flatten(i_src_wdata_flatten),
        .o_cdb_rdy(o_cdb_rdy), .i_cdb_ack(i_cdb_ack),
        .o_cdb_tag(o_cdb_tag), .o_cdb_wdata(o_cdb_wdata), .o_cdb_src(o_cdb_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] rdy;
        logic         cack;
        logic [N-1:0] exp_ack;
    } vec_t;

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        logic [1:0]    src;
    } bc_t;

    bc_t           sb[$];
    bc_t           cur;
    logic          exp_full;
    logic          prev_cack;
    logic [TW-1:0] tg [N];
    logic [DW-1:0] dt [N];
    vec_t          vt [20];
    int            checks = 0;
    int            failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rand_payload();
        for (int k = 0; k < N; k++) begin
            tg[k] = TW'($urandom);
            dt[k] = $urandom;
        end
    endtask

    // One cycle: check slot contents left by the previous edge, drive, check ack.
    task automatic step(input logic [N-1:0] rdy, input logic cack, input logic [N-1:0] exp_ack);
        bc_t e;
        @(negedge clk);
        if (sb.size() > 0) begin
            cur      = sb.pop_front();
            exp_full = 1'b1;
        end else if (prev_cack) begin
            exp_full = 1'b0;
        end
        chk("cdb_rdy", 64'(o_cdb_rdy), 64'(exp_full));
        if (exp_full) begin
            chk("cdb_tag", 64'(o_cdb_tag), 64'(cur.tag));
            chk("cdb_wdata", 64'(o_cdb_wdata), 64'(cur.data));
            chk("cdb_src", 64'(o_cdb_src), 64'(cur.src));
        end
        i_src_rdy = rdy;
        i_cdb_ack = cack;
        for (int k = 0; k < N; k++) begin
            i_src_tag_flatten[k*TW +: TW]   = tg[k];
            i_src_wdata_flatten[k*DW +: DW] = dt[k];
        end
        #1;
        chk("src_ack", 64'(o_src_ack), 64'(exp_ack));
        for (int k = 0; k < N; k++) begin
            if (exp_ack[k]) begin
                e.tag  = tg[k];
                e.data = dt[k];
                e.src  = 2'(k);
                sb.push_back(e);
            end
        end
        prev_cack = cack;
    endtask

    // Reset for one edge with requesters and cdb ack active; ack must stay low.
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        i_src_rdy = '1;
        i_cdb_ack = 1'b1;
        #1;
        chk("rst_src_ack", 64'(o_src_ack), 64'd0);
        @(negedge clk);
        chk("rst_cdb_rdy", 64'(o_cdb_rdy), 64'd0);
        chk("rst_cdb_tag", 64'(o_cdb_tag), 64'd0);
        chk("rst_cdb_wdata", 64'(o_cdb_wdata), 64'd0);
        chk("rst_cdb_src", 64'(o_cdb_src), 64'd0);
        rst       = 1'b0;
        i_src_rdy = '0;
        i_cdb_ack = 1'b0;
        sb.delete();
        exp_full  = 1'b0;
        prev_cack = 1'b0;
    endtask

    initial begin
        // rr pointer after each row noted on the right
        vt[0]  = '{4'b1111, 1'b1, 4'b0001}; // 1
        vt[1]  = '{4'b1111, 1'b1, 4'b0010}; // 2
        vt[2]  = '{4'b1111, 1'b1, 4'b0100}; // 3
        vt[3]  = '{4'b1111, 1'b1, 4'b1000}; // 0
        vt[4]  = '{4'b1111, 1'b1, 4'b0001}; // 1
        vt[5]  = '{4'b1010, 1'b0, 4'b0000}; // stall
        vt[6]  = '{4'b1010, 1'b0, 4'b0000};
        vt[7]  = '{4'b1010, 1'b0, 4'b0000};
        vt[8]  = '{4'b1010, 1'b1, 4'b0010}; // 2
        vt[9]  = '{4'b0100, 1'b1, 4'b0100}; // 3, drain+refill
        vt[10] = '{4'b0000, 1'b1, 4'b0000}; // drain to empty, ptr stays 3
        vt[11] = '{4'b0000, 1'b0, 4'b0000};
        vt[12] = '{4'b1110, 1'b0, 4'b1000}; // 0, loadable while empty
        vt[13] = '{4'b0001, 1'b0, 4'b0000};
        vt[14] = '{4'b0001, 1'b1, 4'b0001}; // 1, wrap
        vt[15] = '{4'b0001, 1'b1, 4'b0001}; // 1
        vt[16] = '{4'b1100, 1'b1, 4'b0100}; // 3
        vt[17] = '{4'b1100, 1'b1, 4'b1000}; // 0
        vt[18] = '{4'b0000, 1'b1, 4'b0000};
        vt[19] = '{4'b0000, 1'b0, 4'b0000};

        exp_full  = 1'b0;
        prev_cack = 1'b0;
        cur       = '{tag: '0, data: '0, src: '0};
        rand_payload();
        repeat (2) @(negedge clk);
        do_reset();

        // Single requester after reset with fixed payload
        tg[2] = 4'd5;
        dt[2] = 32'h1234;
        step(4'b0100, 1'b1, 4'b0100);
        step(4'b0000, 1'b1, 4'b0000);
        chk("fixed_payload_tag", 64'(cur.tag), 64'd5);
        step(4'b0000, 1'b0, 4'b0000);

        // Table: round robin, stall, drain+refill, drain to empty, wrap
        do_reset();
        foreach (vt[i]) begin
            rand_payload();
            step(vt[i].rdy, vt[i].cack, vt[i].exp_ack);
        end

        // Reset while full and stalled discards the broadcast; unit 2 first after
        rand_payload();
        step(4'b0010, 1'b0, 4'b0010);
        step(4'b0000, 1'b0, 4'b0000);
        do_reset();
        rand_payload();
        step(4'b1100, 1'b1, 4'b0100);
        step(4'b1100, 1'b1, 4'b1000);
        step(4'b0000, 1'b1, 4'b0000);
        step(4'b0000, 1'b0, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4, SHALL set the number of functional units sharing the CDB (range 2..8).
REQ-002 Parameter BW_PROCESSOR_DATA, default 32, SHALL set the CDB data width.
REQ-003 Parameter BW_TAG, default 4, SHALL set the reservation-station tag width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 i_src_rdy  input  NUM_SRC  SHALL carry the per-unit result-valid flags.
REQ-007 o_src_ack  output  NUM_SRC  SHALL carry the per-unit accept flags; transfer on rdy&&ack.
REQ-008 i_src_tag_flatten  input  NUM_SRC*BW_TAG  SHALL carry the per-unit tags; unit k occupies slice [k*BW_TAG +: BW_TAG].
REQ-009 i_src_wdata_flatten  input  NUM_SRC*BW_PROCESSOR_DATA  SHALL carry the per-unit results, packed as for tags.
REQ-010 o_cdb_rdy  output  1  SHALL flag a valid broadcast.
REQ-011 i_cdb_ack  input  1  SHALL flag broadcast consumption by the ROB/RS side.
REQ-012 o_cdb_tag  output  BW_TAG  SHALL carry the broadcast tag.
REQ-013 o_cdb_wdata  output  BW_PROCESSOR_DATA  SHALL carry the broadcast data.
REQ-014 o_cdb_src  output  clog2(NUM_SRC)  SHALL carry the index of the unit owning the current broadcast.

Function
REQ-015 The block SHALL hold one registered output slot, states EMPTY (o_cdb_rdy=0) and FULL (o_cdb_rdy=1).
REQ-016 The slot SHALL be loadable in a cycle when EMPTY, or FULL with i_cdb_ack=1 (same-cycle drain and refill).
REQ-017 When loadable and any i_src_rdy is set, the block SHALL grant exactly one unit, the first asserting rdy scanning from pointer rr_ptr upward with wrap from NUM_SRC-1 to 0.
REQ-018 o_src_ack SHALL be one-hot for the granted unit only, combinational in the same cycle, and all-zero when not loadable.
REQ-019 On grant, the next edge SHALL load the unit's tag, data and index into the slot, set FULL, and set rr_ptr to grant+1 modulo NUM_SRC.
REQ-020 With no grant, rr_ptr SHALL hold its value.
REQ-021 FULL with i_cdb_ack=1 and no requester SHALL go to EMPTY next edge.
REQ-022 FULL with i_cdb_ack=0 SHALL hold tag, data, src and rdy stable, and all o_src_ack SHALL be 0.
REQ-023 Latency from accepted request to o_cdb_rdy SHALL be exactly 1 cycle; sustained throughput SHALL be 1 broadcast/cycle while i_cdb_ack=1.
REQ-024 Every unit with rdy held SHALL be granted within NUM_SRC grants (no starvation).
REQ-025 Tag and data SHALL pass bit-exact; no arithmetic on payload.
REQ-026 o_cdb_tag, o_cdb_wdata and o_cdb_src SHALL update only on load; they are don't-care-stable while EMPTY.

Reset
REQ-027 With rst=1 at an edge: o_cdb_rdy=0, o_cdb_tag=0, o_cdb_wdata=0, o_cdb_src=0, rr_ptr=0.
REQ-028 While rst=1, o_src_ack SHALL be all-zero; an in-flight broadcast SHALL be discarded.
REQ-029 The first grant after reset release SHALL favour unit 0.

Verification
REQ-030 After reset, unit 2 rdy, tag=5, wdata=0x1234, ack=1 -> o_src_ack=0100 same cycle; next cycle o_cdb_rdy=1, tag=5, wdata=0x1234, src=2.
REQ-031 All 4 units rdy continuously, i_cdb_ack=1 -> grant order 0,1,2,3,0 on consecutive cycles; one broadcast per cycle.
REQ-032 Slot FULL, i_cdb_ack=0 for 3 cycles with units 1 and 3 rdy -> o_src_ack=0000 and outputs stable for 3 cycles; on ack=1, unit 1 granted.
REQ-033 FULL, ack=1, unit 3 rdy -> same-cycle drain+load; o_cdb_rdy stays 1 and tag changes next edge.
REQ-034 rst=1 asserted while FULL with ack=0 -> next edge o_cdb_rdy=0, all outputs 0; after release with units 2,3 rdy, unit 2 granted first.
REQ-035 FULL, ack=1, no requesters -> o_cdb_rdy=0 next cycle; rr_ptr unchanged.
